odd_even_div: RTL and testbench

//  Programmable integer clock divider, ratio N = div_cfg (2..255), odd or even.

---
 rtl/odd_even_div_pkg.sv | 13 +
 rtl/odd_even_div_cnt.sv | 49 ++++
 rtl/odd_even_div.sv | 50 +++++
 tb/tb_odd_even_div.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/odd_even_div_pkg.sv
// Shared types and helpers for the odd/even programmable clock divider.
package odd_even_div_pkg;
  localparam int CFG_W_DEF = 8;

  typedef logic [CFG_W_DEF-1:0] div_t;

  // High-phase length in posedge cycles: ceil(n/2), computed one bit wider so n=255 does not wrap.
  function automatic div_t half(div_t n);
    logic [CFG_W_DEF:0] s;
    s = {1'b0, n} + 1'b1;
    return div_t'(s >> 1);
  endfunction
endpackage

// File: rtl/odd_even_div_cnt.sv
// Posedge half of the divider: ratio latch, period counter, done pulse, high-phase compare.
module odd_even_div_cnt
  import odd_even_div_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] div_cfg,
  output logic [CFG_W-1:0] cfg_q,
  output logic             pos_q,
  output logic             done
);
  logic [CFG_W-1:0] cnt;
  logic             idle;
  logic             wrap;
  logic             nxt_ok;
  logic [CFG_W:0]   h;

  assign idle   = (cfg_q[CFG_W-1:1] == '0);
  assign wrap   = !idle && (cnt == cfg_q - 1'b1);
  // A ratio below 2 has no period, so the closing pulse is suppressed when entering idle.
  assign nxt_ok = (div_cfg[CFG_W-1:1] != '0);
  assign h      = ({1'b0, cfg_q} + 1'b1) >> 1;

  // Ratio only reloads while idle or on the wrap edge, so a period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      pos_q <= ({1'b0, cnt} < h);
      if (idle) begin
        cfg_q <= div_cfg;
        cnt   <= '0;
        done  <= 1'b0;
      end else if (wrap) begin
        cfg_q <= div_cfg;
        cnt   <= '0;
        done  <= nxt_ok;
      end else begin
        cnt   <= cnt + 1'b1;
        done  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/odd_even_div.sv
// Programmable odd/even clock divider top.
// ODD_DUTY50_EN adds a negedge retime flop so odd ratios get exact 50% duty.
module odd_even_div
  import odd_even_div_pkg::*;
#(
  parameter int CFG_W = CFG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CFG_W-1:0] div_cfg,
  output logic             clko,
  output logic             done
);
  logic [CFG_W-1:0] cfg_q;
  logic             pos_q;
  logic             odd_clk;

  odd_even_div_cnt #(.CFG_W(CFG_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .div_cfg (div_cfg),
    .cfg_q   (cfg_q),
    .pos_q   (pos_q),
    .done    (done)
  );

`ifdef ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy; ANDing trims the odd high phase by half a clk.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= pos_q;
  end

  assign odd_clk = pos_q & neg_q;
`else
  assign odd_clk = pos_q;
`endif

  // Output mux: off for 0, gated pass-through for 1, else even/odd shaping.
  always_comb begin
    clko = 1'b0;
    if (cfg_q == CFG_W'(1))      clko = clk;
    else if (cfg_q != '0) begin
      if (!cfg_q[0])             clko = pos_q;
      else                       clko = odd_clk;
    end
  end
endmodule

// File: tb/tb_odd_even_div.sv
// Directed bench for odd_even_div; counts high half-cycles and done pulses per period.
module tb_odd_even_div;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div_cfg = 8'd0;
  logic       clko;
  logic       done;
  int         total = 0;
  int         bad = 0;

`ifdef ODD_DUTY50_EN
  localparam int ODD_X = 0;
`else
  localparam int ODD_X = 1;
`endif

  odd_even_div #(.CFG_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_cfg (div_cfg),
    .clko    (clko),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; samples clko every half clk and done every posedge for n clks.
  task automatic measure(input int n, output int hi, output int dn);
    hi = 0; dn = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(clko); dn += int'(done);
      @(negedge clk); #1;
      hi += int'(clko);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, int'(done), 1);
  endtask

  task automatic period(input string tag, input int n, input int exp_hi);
    int hi, dn;
    measure(n, hi, dn);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_dn"}, dn, 1);
    chk({tag, "_next_done"}, int'(done), 1);
  endtask

  initial begin
    int hi, dn;
    // reset held with ratio 0
    #1;
    chk("rst_clko", int'(clko), 0);
    chk("rst_done", int'(done), 0);
    measure(20, hi, dn);
    chk("rst_hold_hi", hi, 0);
    chk("rst_hold_dn", dn, 0);
    // release with ratio 0: stays idle
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    measure(10, hi, dn);
    chk("idle0_hi", hi, 0);
    chk("idle0_dn", dn, 0);

    // N=2
    div_cfg = 8'd2;
    wait_done("n2_start", 20);
    period("n2_a", 2, 2);
    period("n2_b", 2, 2);

    // switch 2 -> 11 with the 2-period in progress
    div_cfg = 8'd11;
    period("sw_old2", 2, 2);
    period("sw_new11", 11, 11 + ODD_X);
    period("n11_b", 11, 11 + ODD_X);

    // N=4
    div_cfg = 8'd4;
    period("to4_old11", 11, 11 + ODD_X);
    period("n4_a", 4, 4);
    period("n4_b", 4, 4);

    // N=255
    div_cfg = 8'd255;
    period("to255_old4", 4, 4);
    period("n255", 255, 255 + ODD_X);

    // N=1: gated pass-through, no done (closing pulse of the 255 period suppressed)
    div_cfg = 8'd1;
    measure(255, hi, dn);
    chk("to1_old255_hi", hi, 255 + ODD_X);
    chk("to1_old255_dn", dn, 1);
    chk("n1_done_off", int'(done), 0);
    measure(4, hi, dn);
    chk("n1_hi", hi, 4);
    chk("n1_dn", dn, 0);

    // N=11 then reset mid-period
    div_cfg = 8'd11;
    wait_done("n11_start", 30);
    period("n11_c", 11, 11 + ODD_X);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("pre_rst_clko", int'(clko), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_clko", int'(clko), 0);
    chk("async_rst_done", int'(done), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_load_clko", int'(clko), 0);
    @(posedge clk); #1;
    chk("rel_rise_pos", int'(clko), ODD_X);
    @(negedge clk); #1;
    chk("rel_rise_neg", int'(clko), 1);
    wait_done("rel_done", 30);
    period("rel_n11", 11, 11 + ODD_X);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
